plcp_header_gen: RTL

//  802.11b 1 Mbps DSSS PLCP preamble/header serializer. Upstream of the scrambler/DBPSK

---
 rtl/plcp_header_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/plcp_header_gen.sv
// 802.11b long-preamble PLCP serializer: SYNC, SFD, SIGNAL/SERVICE/LENGTH and header CRC,
// one bit per accepted beat, driving an external serial CRC-16 over the 32 header bits.
module plcp_header_gen #(
  parameter int unsigned SYNC_LEN   = 128,
  parameter logic [15:0] SFD_VAL    = 16'hF3A0,
  parameter logic [7:0]  SIGNAL_VAL = 8'h0A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  service,
  input  logic [15:0] length_us,
  output logic        busy,
  output logic        bit_out,
  output logic        bit_valid,
  input  logic        bit_ready,
  output logic        hdr_done,
  output logic        crc_init,
  output logic        crc_en,
  output logic        crc_bit,
  input  logic [15:0] crc_value
);

  typedef enum logic [2:0] {IDLE, SYNC, SFD, HDR, CRC, DONE} state_t;

  localparam logic [7:0] SYNC_LAST = 8'(SYNC_LEN - 1);

  state_t      state;
  state_t      next_field;
  logic [7:0]  cnt;
  logic [7:0]  service_q;
  logic [15:0] length_q;
  logic [31:0] hdr_word;
  logic        accept;
  logic        field_last;

  assign hdr_word = {length_q, service_q, SIGNAL_VAL};
  assign accept   = bit_valid & bit_ready;

  // bit_out is decoded from registered state/count so it holds across stalls; the CRC
  // field reads crc_value live because the external CRC settles on the last HDR accept edge.
  always_comb begin
    bit_out    = 1'b0;
    field_last = 1'b0;
    next_field = IDLE;
    case (state)
      SYNC: begin
        bit_out    = 1'b1;
        field_last = (cnt == SYNC_LAST);
        next_field = SFD;
      end
      SFD: begin
        bit_out    = SFD_VAL[cnt[3:0]];
        field_last = (cnt == 8'd15);
        next_field = HDR;
      end
      HDR: begin
        bit_out    = hdr_word[cnt[4:0]];
        field_last = (cnt == 8'd31);
        next_field = CRC;
      end
      CRC: begin
        bit_out    = crc_value[4'd15 - cnt[3:0]];
        field_last = (cnt == 8'd15);
        next_field = DONE;
      end
      default: ;
    endcase
  end

  assign crc_en  = accept & (state == HDR);
  assign crc_bit = bit_out & (state == HDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      service_q <= '0;
      length_q  <= '0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      hdr_done  <= 1'b0;
      crc_init  <= 1'b0;
    end else begin
      crc_init <= 1'b0;
      hdr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            service_q <= service;
            length_q  <= length_us;
            crc_init  <= 1'b1;
            bit_valid <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
            state     <= SYNC;
          end
        end
        SYNC, SFD, HDR, CRC: begin
          if (accept) begin
            if (field_last) begin
              cnt   <= '0;
              state <= next_field;
              if (state == CRC) begin
                bit_valid <= 1'b0;
                busy      <= 1'b0;
                hdr_done  <= 1'b1;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
